// File: rtl/gpr_file_mp.sv
// rtl/gpr_file_mp.sv - multi-port register file with clear sweep, bypass and busy scoreboard
module gpr_file_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRP      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                         clk_i,
    input  logic                         resetn_i,
    input  logic                         clr_i,
    output logic                         ready_o,
    input  logic                         we0_i,
    input  logic [$clog2(NREGS)-1:0]     wa0_i,
    input  logic [XLEN-1:0]              wd0_i,
    input  logic                         we1_i,
    input  logic [$clog2(NREGS)-1:0]     wa1_i,
    input  logic [XLEN-1:0]              wd1_i,
    input  logic [NRP*$clog2(NREGS)-1:0] ra_i,
    output logic [NRP*XLEN-1:0]          rd_o,
    output logic [NRP-1:0]               rbusy_o,
    input  logic                         rsv_en_i,
    input  logic [$clog2(NREGS)-1:0]     rsv_addr_i
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [XLEN-1:0]   mem_q [NREGS];

    logic sweep_en, accept, wr0_en, wr1_en, rsv_ok;

    assign ready_o = (state_q == RUN);

    // A clr cycle drops all traffic so the sweep starts from a quiet file.
    assign accept   = resetn_i && (state_q == RUN) && !clr_i;
    assign sweep_en = resetn_i && (state_q == CLEAR);
    assign wr0_en   = accept && we0_i && !((ZERO_REG != 0) && (wa0_i == '0));
    assign wr1_en   = accept && we1_i && !((ZERO_REG != 0) && (wa1_i == '0));
    assign rsv_ok   = accept && rsv_en_i && !((ZERO_REG != 0) && (rsv_addr_i == '0));

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            CLEAR: begin
                if (cnt_q == LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (clr_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    busy_d  = '0;
                end else begin
                    // Reservation is applied last so it wins over a same-address write.
                    if (wr0_en) busy_d[wa0_i] = 1'b0;
                    if (wr1_en) busy_d[wa1_i] = 1'b0;
                    if (rsv_ok) busy_d[rsv_addr_i] = 1'b1;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (sweep_en) begin
            mem_q[cnt_q] <= '0;
        end else begin
            if (wr0_en) mem_q[wa0_i] <= wd0_i;
            if (wr1_en) mem_q[wa1_i] <= wd1_i;
        end
    end

    for (genvar i = 0; i < NRP; i++) begin : g_rport
        logic [AW-1:0] addr;
        logic          zr, hit0, hit1, fwd;

        assign addr = ra_i[i*AW +: AW];
        assign zr   = (ZERO_REG != 0) && (addr == '0);
        assign hit0 = we0_i && (wa0_i == addr) && !zr;
        assign hit1 = we1_i && (wa1_i == addr) && !zr;
        assign fwd  = (BYPASS != 0) && ready_o && (hit0 || hit1);

        assign rd_o[i*XLEN +: XLEN] = (!ready_o || zr) ? '0 :
                                      fwd ? (hit1 ? wd1_i : wd0_i) : mem_q[addr];
        assign rbusy_o[i] = ready_o && !fwd && busy_q[addr];
    end

endmodule

// File: tb/tb_gpr_file_mp.sv
// tb/tb_gpr_file_mp.sv - directed bench for gpr_file_mp with bypass on and off
module tb_gpr_file_mp;
    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NRP = 2;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            resetn, clr, we0, we1, rsv_en;
    logic [AW-1:0]   wa0, wa1, rsv_addr, ra0, ra1;
    logic [XLEN-1:0] wd0, wd1;
    logic [NRP*AW-1:0]   ra;
    logic [NRP*XLEN-1:0] rd_b, rd_n;
    logic [NRP-1:0]      rbusy_b, rbusy_n;
    logic                ready_b, ready_n;

    int checks = 0;
    int failures = 0;

    assign ra = {ra1, ra0};

    always #5 clk = ~clk;

    gpr_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk_i(clk), .resetn_i(resetn), .clr_i(clr), .ready_o(ready_b),
        .we0_i(we0), .wa0_i(wa0), .wd0_i(wd0),
        .we1_i(we1), .wa1_i(wa1), .wd1_i(wd1),
        .ra_i(ra), .rd_o(rd_b), .rbusy_o(rbusy_b),
        .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr)
    );

    gpr_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk_i(clk), .resetn_i(resetn), .clr_i(clr), .ready_o(ready_n),
        .we0_i(we0), .wa0_i(wa0), .wd0_i(wd0),
        .we1_i(we1), .wa1_i(wa1), .wd1_i(wd1),
        .ra_i(ra), .rd_o(rd_n), .rbusy_o(rbusy_n),
        .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr = 0; we0 = 0; we1 = 0; rsv_en = 0;
    endtask

    initial begin
        resetn = 0; idle();
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; rsv_addr = '0; ra0 = '0; ra1 = '0;
        repeat (3) tick();
        chk("rst_ready_b", 32'(ready_b), 32'd0);
        chk("rst_ready_n", 32'(ready_n), 32'd0);
        chk("rst_rd", rd_b[31:0], 32'd0);
        chk("rst_rbusy", 32'(rbusy_b), 32'd0);

        resetn = 1;
        ra0 = 5'd5; ra1 = 5'd31;
        for (int k = 0; k < NREGS; k++) begin
            #1;
            chk("sweep_ready", 32'(ready_b), 32'd0);
            chk("sweep_rd0", rd_b[31:0], 32'd0);
            chk("sweep_rd1", rd_n[63:32], 32'd0);
            tick();
        end
        chk("sweep_done_b", 32'(ready_b), 32'd1);
        chk("sweep_done_n", 32'(ready_n), 32'd1);
        chk("swept_r5", rd_b[31:0], 32'd0);
        chk("swept_r31", rd_n[63:32], 32'd0);

        // dual write, same address: port 1 wins
        we0 = 1; wa0 = 5'd5; wd0 = 32'hAAAA_0000;
        we1 = 1; wa1 = 5'd5; wd1 = 32'h1234_5678;
        ra0 = 5'd5;
        #1;
        chk("dual_byp_b", rd_b[31:0], 32'h1234_5678);
        chk("dual_byp_n", rd_n[31:0], 32'h0000_0000);
        tick(); idle();
        #1;
        chk("dual_b", rd_b[31:0], 32'h1234_5678);
        chk("dual_n", rd_n[31:0], 32'h1234_5678);

        // bypass on read port 1
        we0 = 1; wa0 = 5'd7; wd0 = 32'hDEAD_BEEF; ra1 = 5'd7;
        #1;
        chk("byp_b", rd_b[63:32], 32'hDEAD_BEEF);
        chk("byp_n_old", rd_n[63:32], 32'h0000_0000);
        tick(); idle();
        #1;
        chk("byp_b_after", rd_b[63:32], 32'hDEAD_BEEF);
        chk("byp_n_after", rd_n[63:32], 32'hDEAD_BEEF);

        // zero register
        we0 = 1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF; rsv_en = 1; rsv_addr = 5'd0; ra0 = 5'd0;
        #1;
        chk("zero_rd_same", rd_b[31:0], 32'd0);
        chk("zero_busy_same", 32'(rbusy_b[0]), 32'd0);
        tick(); idle();
        #1;
        chk("zero_rd_b", rd_b[31:0], 32'd0);
        chk("zero_rd_n", rd_n[31:0], 32'd0);
        chk("zero_busy_b", 32'(rbusy_b[0]), 32'd0);
        chk("zero_busy_n", 32'(rbusy_n[0]), 32'd0);

        // scoreboard
        rsv_en = 1; rsv_addr = 5'd9; ra0 = 5'd9;
        #1;
        chk("rsv_same", 32'(rbusy_b[0]), 32'd0);
        tick(); idle();
        #1;
        chk("rsv_b", 32'(rbusy_b[0]), 32'd1);
        chk("rsv_n", 32'(rbusy_n[0]), 32'd1);
        we1 = 1; wa1 = 5'd9; wd1 = 32'h0000_0099;
        #1;
        chk("wr_fwd_busy_b", 32'(rbusy_b[0]), 32'd0);
        chk("wr_fwd_busy_n", 32'(rbusy_n[0]), 32'd1);
        tick(); idle();
        #1;
        chk("wr_clr_b", 32'(rbusy_b[0]), 32'd0);
        chk("wr_clr_n", 32'(rbusy_n[0]), 32'd0);
        chk("wr_r9", rd_n[31:0], 32'h0000_0099);
        we0 = 1; wa0 = 5'd9; wd0 = 32'h0000_0055; rsv_en = 1; rsv_addr = 5'd9;
        tick(); idle();
        #1;
        chk("rsv_wins_b", 32'(rbusy_b[0]), 32'd1);
        chk("rsv_wins_n", 32'(rbusy_n[0]), 32'd1);
        chk("rsv_wins_rd", rd_n[31:0], 32'h0000_0055);

        // mid-run clear with a colliding write
        we0 = 1; wa0 = 5'd3; wd0 = 32'h0000_0033;
        tick(); idle();
        ra0 = 5'd3;
        #1;
        chk("pre_clr_r3", rd_n[31:0], 32'h0000_0033);
        clr = 1; we0 = 1; wa0 = 5'd3; wd0 = 32'h0000_0BAD; rsv_en = 1; rsv_addr = 5'd10;
        tick(); idle();
        for (int k = 0; k < NREGS; k++) begin
            #1;
            chk("clr_ready", 32'(ready_b), 32'd0);
            chk("clr_rd", rd_b[31:0], 32'd0);
            chk("clr_rbusy", 32'(rbusy_b), 32'd0);
            tick();
        end
        chk("clr_done_b", 32'(ready_b), 32'd1);
        chk("clr_done_n", 32'(ready_n), 32'd1);
        for (int r = 0; r < NREGS; r++) begin
            ra0 = AW'(r); ra1 = AW'(r);
            #1;
            chk("post_clr_rd_n", rd_n[31:0], 32'd0);
            chk("post_clr_rd_b", rd_b[63:32], 32'd0);
            chk("post_clr_busy", 32'({rbusy_b, rbusy_n}), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
